// File: rtl/sbus_clock_reset_sequencer.sv
// rtl/sbus_clock_reset_sequencer.sv - staggered bring-up and software reset pulses for the sbus clock group
module sbus_clock_reset_sequencer #(
  parameter int N_MEMBERS         = 4,
  parameter int RESET_HOLD_CYCLES = 16,
  parameter int STAGGER_CYCLES    = 4,
  parameter int CNT_W             = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic [N_MEMBERS-1:0] out_member_clock_en,
  output logic [N_MEMBERS-1:0] out_member_reset,
  output logic                 all_up,
  input  logic                 sw_reset_req_valid,
  input  logic [N_MEMBERS-1:0] sw_reset_req_mask,
  output logic                 sw_reset_req_ready,
  output logic                 sw_reset_done
);

  localparam int IDX_W = (N_MEMBERS > 1) ? $clog2(N_MEMBERS) : 1;

  // Counters compare against "last" values so each phase spends exactly its cycle count.
  localparam logic [CNT_W-1:0]     HOLD_LAST    = CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]     STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [CNT_W-1:0]     QUIESCE_LAST = CNT_W'(1);
  localparam logic [IDX_W-1:0]     IDX_LAST     = IDX_W'(N_MEMBERS - 1);
  localparam logic [N_MEMBERS-1:0] ALL_ONES     = '1;
  localparam logic [N_MEMBERS-1:0] MEMBER0      = N_MEMBERS'(1);

  typedef enum logic [2:0] {
    S_HOLD,
    S_RELEASE,
    S_RUN,
    S_QUIESCE,
    S_SWRESET
  } state_t;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [IDX_W-1:0]       idx_q;
  logic [N_MEMBERS-1:0]   mask_q;
  logic [N_MEMBERS-1:0]   clk_en_q;
  logic [N_MEMBERS-1:0]   rst_q;
  logic                   all_up_q;
  logic                   ready_q;
  logic                   done_q;

  logic [IDX_W-1:0]       idx_d;
  logic [N_MEMBERS-1:0]   release_bit_d;

  // Next member to release during bring-up and its one-hot position.
  assign idx_d         = idx_q + IDX_W'(1);
  assign release_bit_d = MEMBER0 << idx_d;

  assign out_member_clock_en = clk_en_q;
  assign out_member_reset    = rst_q;
  assign all_up              = all_up_q;
  assign sw_reset_req_ready  = ready_q;
  assign sw_reset_done       = done_q;

  // Sequencer FSM: every output is a register updated here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_HOLD;
      cnt_q    <= '0;
      idx_q    <= '0;
      mask_q   <= '0;
      clk_en_q <= ALL_ONES;
      rst_q    <= ALL_ONES;
      all_up_q <= 1'b0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_q <= S_RELEASE;
            rst_q   <= rst_q & ~MEMBER0;
            idx_q   <= '0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_RELEASE: begin
          // One extra cycle after the last release before declaring the group up.
          if (idx_q == IDX_LAST) begin
            state_q  <= S_RUN;
            all_up_q <= 1'b1;
            ready_q  <= 1'b1;
            cnt_q    <= '0;
          end else if (cnt_q == STAGGER_LAST) begin
            rst_q <= rst_q & ~release_bit_d;
            idx_q <= idx_d;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_RUN: begin
          if (sw_reset_req_valid && ready_q) begin
            mask_q <= sw_reset_req_mask;
            if (sw_reset_req_mask != '0) begin
              state_q  <= S_QUIESCE;
              clk_en_q <= clk_en_q & ~sw_reset_req_mask;
              rst_q    <= rst_q | sw_reset_req_mask;
              all_up_q <= 1'b0;
              ready_q  <= 1'b0;
              cnt_q    <= '0;
            end else begin
              // Empty mask: nothing to reset, just acknowledge.
              done_q <= 1'b1;
            end
          end
        end
        S_QUIESCE: begin
          if (cnt_q == QUIESCE_LAST) begin
            state_q  <= S_SWRESET;
            clk_en_q <= clk_en_q | mask_q;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_SWRESET: begin
          if (cnt_q == HOLD_LAST) begin
            state_q  <= S_RUN;
            rst_q    <= rst_q & ~mask_q;
            all_up_q <= 1'b1;
            ready_q  <= 1'b1;
            done_q   <= 1'b1;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_HOLD;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sbus_clock_reset_sequencer.sv
// tb/tb_sbus_clock_reset_sequencer.sv - scoreboard bench for sbus_clock_reset_sequencer
module tb_sbus_clock_reset_sequencer;

  logic       clk;
  logic       reset;
  logic [3:0] clock_en;
  logic [3:0] member_reset;
  logic       all_up;
  logic       req_valid;
  logic [3:0] req_mask;
  logic       req_ready;
  logic       done;

  sbus_clock_reset_sequencer #(
    .N_MEMBERS(4),
    .RESET_HOLD_CYCLES(16),
    .STAGGER_CYCLES(4),
    .CNT_W(8)
  ) dut (
    .clock(clk),
    .reset(reset),
    .out_member_clock_en(clock_en),
    .out_member_reset(member_reset),
    .all_up(all_up),
    .sw_reset_req_valid(req_valid),
    .sw_reset_req_mask(req_mask),
    .sw_reset_req_ready(req_ready),
    .sw_reset_done(done)
  );

  typedef struct {
    int       at;
    logic [3:0] rst;
    logic [3:0] en;
    logic     up;
    logic     rdy;
    logic     dn;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  int   edge_n = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_n <= edge_n + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic expect_at(input int at, input logic [3:0] rst, input logic [3:0] en,
                           input logic up, input logic rdy, input logic dn);
    exp_t e;
    e.at = at; e.rst = rst; e.en = en; e.up = up; e.rdy = rdy; e.dn = dn;
    exp_q.push_back(e);
  endtask

  task automatic goto(input int c);
    while (edge_n < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_bringup(input int c0);
    expect_at(c0,      4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0);
    expect_at(c0 + 15, 4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0);
    expect_at(c0 + 16, 4'b1110, 4'b1111, 1'b0, 1'b0, 1'b0);
    expect_at(c0 + 19, 4'b1110, 4'b1111, 1'b0, 1'b0, 1'b0);
    expect_at(c0 + 20, 4'b1100, 4'b1111, 1'b0, 1'b0, 1'b0);
    expect_at(c0 + 23, 4'b1100, 4'b1111, 1'b0, 1'b0, 1'b0);
    expect_at(c0 + 24, 4'b1000, 4'b1111, 1'b0, 1'b0, 1'b0);
    expect_at(c0 + 27, 4'b1000, 4'b1111, 1'b0, 1'b0, 1'b0);
    expect_at(c0 + 28, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0);
    expect_at(c0 + 29, 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b0);
  endtask

  // Monitor: compares output snapshots due this cycle and every done pulse seen.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].at <= edge_n) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (e.at != edge_n) begin
        n_errors++;
        $display("FAIL snapshot_missed: cycle=%0d due at %0d", edge_n, e.at);
      end else if (member_reset !== e.rst || clock_en !== e.en || all_up !== e.up ||
                   req_ready !== e.rdy || done !== e.dn) begin
        n_errors++;
        $display("FAIL snapshot@%0d: got rst=%b en=%b up=%b rdy=%b done=%b, want rst=%b en=%b up=%b rdy=%b done=%b",
                 edge_n, member_reset, clock_en, all_up, req_ready, done,
                 e.rst, e.en, e.up, e.rdy, e.dn);
      end
    end
    if (done === 1'b1) begin
      n_checks++;
      if (done_q.size() == 0) begin
        n_errors++;
        $display("FAIL done_unexpected: pulse at cycle %0d, none expected", edge_n);
      end else begin
        int d;
        d = done_q.pop_front();
        if (d != edge_n) begin
          n_errors++;
          $display("FAIL done_time: pulse at cycle %0d, expected at %0d", edge_n, d);
        end
      end
    end
  end

  initial begin
    int c0, t, t2, t3, t5, c1;
    reset = 1'b1;
    req_valid = 1'b0;
    req_mask = 4'b0000;

    // Bring-up from reset.
    goto(3);
    c0 = edge_n;
    push_bringup(c0);
    reset = 1'b0;

    // Software reset of members 0 and 2.
    t = c0 + 32;
    goto(t);
    expect_at(t,      4'b0000, 4'b1111, 1'b1, 1'b1, 1'b0);
    expect_at(t + 1,  4'b0101, 4'b1010, 1'b0, 1'b0, 1'b0);
    expect_at(t + 2,  4'b0101, 4'b1010, 1'b0, 1'b0, 1'b0);
    expect_at(t + 3,  4'b0101, 4'b1111, 1'b0, 1'b0, 1'b0);
    expect_at(t + 18, 4'b0101, 4'b1111, 1'b0, 1'b0, 1'b0);
    expect_at(t + 19, 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b1);
    expect_at(t + 20, 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b0);
    done_q.push_back(t + 19);
    req_valid = 1'b1;
    req_mask = 4'b0101;
    goto(t + 1);
    req_valid = 1'b0;
    req_mask = 4'b0000;

    // Two consecutive empty-mask requests.
    t2 = t + 22;
    goto(t2);
    expect_at(t2 + 1, 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b1);
    expect_at(t2 + 2, 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b1);
    expect_at(t2 + 3, 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b0);
    done_q.push_back(t2 + 1);
    done_q.push_back(t2 + 2);
    req_valid = 1'b1;
    req_mask = 4'b0000;
    goto(t2 + 2);
    req_valid = 1'b0;

    // Back-to-back 0001 then 0010 with valid held.
    t3 = t2 + 5;
    goto(t3);
    expect_at(t3,      4'b0000, 4'b1111, 1'b1, 1'b1, 1'b0);
    expect_at(t3 + 1,  4'b0001, 4'b1110, 1'b0, 1'b0, 1'b0);
    expect_at(t3 + 2,  4'b0001, 4'b1110, 1'b0, 1'b0, 1'b0);
    expect_at(t3 + 3,  4'b0001, 4'b1111, 1'b0, 1'b0, 1'b0);
    expect_at(t3 + 18, 4'b0001, 4'b1111, 1'b0, 1'b0, 1'b0);
    expect_at(t3 + 19, 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b1);
    expect_at(t3 + 20, 4'b0010, 4'b1101, 1'b0, 1'b0, 1'b0);
    expect_at(t3 + 23, 4'b0010, 4'b1111, 1'b0, 1'b0, 1'b0);
    expect_at(t3 + 38, 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b1);
    expect_at(t3 + 39, 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b0);
    done_q.push_back(t3 + 19);
    done_q.push_back(t3 + 38);
    req_valid = 1'b1;
    req_mask = 4'b0001;
    goto(t3 + 1);
    req_mask = 4'b0010;
    goto(t3 + 20);
    req_valid = 1'b0;
    req_mask = 4'b0000;

    // Reset during a 0011 software reset, then bring-up with a request held pending.
    t5 = t3 + 42;
    c1 = t5 + 7;
    goto(t5);
    expect_at(t5 + 1, 4'b0011, 4'b1100, 1'b0, 1'b0, 1'b0);
    expect_at(t5 + 5, 4'b0011, 4'b1111, 1'b0, 1'b0, 1'b0);
    expect_at(t5 + 6, 4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0);
    push_bringup(c1);
    expect_at(c1 + 30, 4'b1000, 4'b0111, 1'b0, 1'b0, 1'b0);
    expect_at(c1 + 33, 4'b1000, 4'b1111, 1'b0, 1'b0, 1'b0);
    expect_at(c1 + 47, 4'b1000, 4'b1111, 1'b0, 1'b0, 1'b0);
    expect_at(c1 + 48, 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b1);
    expect_at(c1 + 49, 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b0);
    done_q.push_back(c1 + 48);
    req_valid = 1'b1;
    req_mask = 4'b0011;
    goto(t5 + 1);
    req_valid = 1'b0;
    goto(t5 + 5);
    reset = 1'b1;
    req_valid = 1'b1;
    req_mask = 4'b1000;
    goto(c1);
    reset = 1'b0;
    goto(c1 + 30);
    req_valid = 1'b0;
    req_mask = 4'b0000;

    goto(c1 + 55);
    n_checks++;
    if (done_q.size() != 0 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL leftover: done pending=%0d snapshots pending=%0d, want 0 and 0",
               done_q.size(), exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
